// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } hz_state_e;

    // Per-pipeline-register control bundle; flush wins over en at the register
    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t BUBBLE = '{en: 1'b0, flush: 1'b1};
    localparam stage_ctrl_t HOLD   = '{en: 1'b0, flush: 1'b0};
    localparam stage_ctrl_t LOAD   = '{en: 1'b1, flush: 1'b0};

    // Load in EX writes a non-zero register that the instruction in ID reads
    function automatic logic lu_hazard(
        input logic             ex_mem_read,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt,
        input logic             id_uses_rt
    );
        logic rs_hit;
        logic rt_hit;
        rs_hit = (ex_rt == id_rs);
        rt_hit = id_uses_rt & (ex_rt == id_rt);
        return ex_mem_read & (ex_rt != REG_W'(0)) & (rs_hit | rt_hit);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register/PC sequencing: load-use stall, MEM-stage branch flush,
// data-memory wait freeze with watchdog, and stall/flush perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned WAIT_W   = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_ex_memRead,
    input  logic [4:0]       id_ex_rt,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_usesRt,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             pc_sel_branch,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             mem_wb_en,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    import pipe_ctrl_pkg::*;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic              br_pend_q, br_pend_d;

    logic              mem_stall_c;
    logic              frozen_c;
    logic              br_raw_c;
    logic              br_take_c;
    logic              lu_c;

    stage_ctrl_t       if_id_c, id_ex_c, ex_mem_c, mem_wb_c;
    logic              pc_en_c, pc_sel_c;

    assign mem_stall_c = mem_req & ~mem_ready;
    assign frozen_c    = (state_q == ST_ERR) | mem_stall_c;
    assign br_raw_c    = mem_branch & mem_zero;
    // A branch seen during a freeze is remembered until the freeze lifts
    assign br_take_c   = ~frozen_c & (br_raw_c | br_pend_q);
    assign br_pend_d   = frozen_c & (br_pend_q | br_raw_c);
    assign lu_c        = lu_hazard(id_ex_memRead, id_ex_rt, if_id_rs, if_id_rt, if_id_usesRt);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            br_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            br_pend_q  <= br_pend_d;
        end
    end

    // Memory wait tracking and watchdog
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall_c) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = ST_ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Stage controls: reset > freeze > branch > load-use > normal
    always_comb begin
        if_id_c  = LOAD;
        id_ex_c  = LOAD;
        ex_mem_c = LOAD;
        mem_wb_c = LOAD;
        pc_en_c  = 1'b1;
        pc_sel_c = 1'b0;
        if (rst) begin
            if_id_c  = BUBBLE;
            id_ex_c  = BUBBLE;
            ex_mem_c = BUBBLE;
            mem_wb_c = BUBBLE;
            pc_en_c  = 1'b0;
        end else if (frozen_c) begin
            if_id_c  = HOLD;
            id_ex_c  = HOLD;
            ex_mem_c = HOLD;
            mem_wb_c = HOLD;
            pc_en_c  = 1'b0;
        end else if (br_take_c) begin
            if_id_c  = BUBBLE;
            id_ex_c  = BUBBLE;
            ex_mem_c = BUBBLE;
            pc_sel_c = 1'b1;
        end else if (lu_c) begin
            if_id_c  = HOLD;
            id_ex_c  = BUBBLE;
            pc_en_c  = 1'b0;
        end
    end

    assign pc_en         = pc_en_c;
    assign pc_sel_branch = pc_sel_c;
    assign if_id_en      = if_id_c.en;
    assign if_id_flush   = if_id_c.flush;
    assign id_ex_en      = id_ex_c.en;
    assign id_ex_flush   = id_ex_c.flush;
    assign ex_mem_en     = ex_mem_c.en;
    assign ex_mem_flush  = ex_mem_c.flush;
    assign mem_wb_en     = mem_wb_c.en;
    assign mem_wb_flush  = mem_wb_c.flush;
    assign mem_err       = mem_err_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~pc_en_c),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_take_c),
        .count (flush_events)
    );

endmodule
